// File: rtl/product_accumulator_if.sv
// Product-stream input and result output handshake bundle for product_accumulator.
interface product_accumulator_if #(
    parameter int unsigned ACC_W = 72,
    parameter int unsigned CNT_W = 9
);
    localparam int unsigned PROD_W = 64;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_overflow;

    modport master (
        output in_valid, in_product, in_last, clear, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow
    );

    modport slave (
        input  in_valid, in_product, in_last, clear, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums runs of 64-bit unsigned products (closed by a last flag or MAX_TERMS) and
// presents sum, term count and sticky overflow on a valid/ready result port.
module product_accumulator #(
    parameter int unsigned ACC_W     = 72,
    parameter int unsigned MAX_TERMS = 256,
    parameter int unsigned CNT_W     = 9
) (
    input logic                 clk,
    input logic                 rst,
    product_accumulator_if.slave bus
);
    typedef enum logic {ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_overflow_q, out_overflow_d;

    logic [ACC_W-1:0]   base_acc;
    logic [CNT_W-1:0]   base_cnt;
    logic               base_ovf;
    logic [CNT_W-1:0]   next_cnt;
    logic [ACC_W:0]     sum;
    logic               ready;
    logic               take;
    logic               closes;

    // Ready while accumulating, or when the held result is popped this cycle.
    assign ready = !rst && ((state_q == ACCUM) || bus.out_ready);

    assign bus.in_ready     = ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = out_sum_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_overflow = out_overflow_q;

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        out_valid_d    = out_valid_q;
        out_sum_d      = out_sum_q;
        out_count_d    = out_count_q;
        out_overflow_d = out_overflow_q;

        // A beat taken in DONE is the first term of a fresh run.
        base_acc = (state_q == ACCUM) ? acc_q : '0;
        base_cnt = (state_q == ACCUM) ? cnt_q : '0;
        base_ovf = (state_q == ACCUM) ? ovf_q : 1'b0;

        sum      = {1'b0, base_acc} + (ACC_W+1)'(bus.in_product);
        next_cnt = base_cnt + CNT_W'(1);
        take     = bus.in_valid && ready && !bus.clear;
        closes   = take && (bus.in_last || (next_cnt == CNT_W'(MAX_TERMS)));

        if ((state_q == DONE) && bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
        end

        if (bus.clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (closes) begin
            out_sum_d      = sum[ACC_W-1:0];
            out_count_d    = next_cnt;
            out_overflow_d = base_ovf | sum[ACC_W];
            out_valid_d    = 1'b1;
            state_d        = DONE;
            acc_d          = '0;
            cnt_d          = '0;
            ovf_d          = 1'b0;
        end else if (take) begin
            acc_d = sum[ACC_W-1:0];
            cnt_d = next_cnt;
            ovf_d = base_ovf | sum[ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ACCUM;
            acc_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            out_valid_q    <= out_valid_d;
            out_sum_q      <= out_sum_d;
            out_count_q    <= out_count_d;
            out_overflow_q <= out_overflow_d;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 72-bit and a 64-bit instance share one stimulus
// stream and are compared each cycle against a run-level reference model.
module tb_product_accumulator;
    localparam int unsigned MAX_TERMS = 256;
    localparam int unsigned CNT_W     = 9;
    localparam int unsigned WIDE_W    = 72;
    localparam int unsigned NARROW_W  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_product;
    logic        in_last;
    logic        clear;
    logic        out_ready;

    always #5 clk = ~clk;

    product_accumulator_if #(.ACC_W(WIDE_W),   .CNT_W(CNT_W)) wb ();
    product_accumulator_if #(.ACC_W(NARROW_W), .CNT_W(CNT_W)) nb ();

    assign wb.in_valid   = in_valid;
    assign wb.in_product = in_product;
    assign wb.in_last    = in_last;
    assign wb.clear      = clear;
    assign wb.out_ready  = out_ready;
    assign nb.in_valid   = in_valid;
    assign nb.in_product = in_product;
    assign nb.in_last    = in_last;
    assign nb.clear      = clear;
    assign nb.out_ready  = out_ready;

    product_accumulator #(.ACC_W(WIDE_W), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) u_wide (
        .clk (clk),
        .rst (rst),
        .bus (wb)
    );

    product_accumulator #(.ACC_W(NARROW_W), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) u_narrow (
        .clk (clk),
        .rst (rst),
        .bus (nb)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: exact (unwrapped) run total plus the pending published result.
    logic [79:0] run_sum;
    int          run_cnt;
    bit          res_valid;
    logic [79:0] res_sum;
    int          res_cnt;
    logic        last_ready;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        check("w_valid", 80'(wb.out_valid),    80'(res_valid));
        check("w_sum",   80'(wb.out_sum),      80'(res_sum[WIDE_W-1:0]));
        check("w_count", 80'(wb.out_count),    80'(res_cnt));
        check("w_ovf",   80'(wb.out_overflow), 80'(res_sum[79:WIDE_W] != '0));
        check("n_valid", 80'(nb.out_valid),    80'(res_valid));
        check("n_sum",   80'(nb.out_sum),      80'(res_sum[NARROW_W-1:0]));
        check("n_count", 80'(nb.out_count),    80'(res_cnt));
        check("n_ovf",   80'(nb.out_overflow), 80'(res_sum[79:NARROW_W] != '0));
    endtask

    // One clock: apply inputs, check in_ready, advance the model, check registered outputs.
    task automatic cycle(input logic v, input logic [63:0] p, input logic l,
                         input logic c, input logic r);
        logic exp_ready;
        in_valid   = v;
        in_product = p;
        in_last    = l;
        clear      = c;
        out_ready  = r;
        #1;
        exp_ready  = !rst && (!res_valid || r);
        last_ready = wb.in_ready;
        check("w_in_ready", 80'(wb.in_ready), 80'(exp_ready));
        check("n_in_ready", 80'(nb.in_ready), 80'(exp_ready));
        if (rst) begin
            run_sum = '0; run_cnt = 0; res_valid = 0; res_sum = '0; res_cnt = 0;
        end else begin
            if (res_valid && r) res_valid = 0;
            if (c) begin
                run_sum = '0; run_cnt = 0;
            end else if (v && exp_ready) begin
                run_sum = run_sum + 80'(p);
                run_cnt++;
                if (l || run_cnt == int'(MAX_TERMS)) begin
                    res_valid = 1; res_sum = run_sum; res_cnt = run_cnt;
                    run_sum = '0; run_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    logic [63:0] bb_val  [5] = '{64'd1, 64'd2, 64'd10, 64'd3, 64'd4};
    logic        bb_last [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [79:0] bb_sum  [3] = '{80'd3, 80'd10, 80'd7};
    int          bb_cnt  [3] = '{2, 1, 2};

    initial begin
        int k;
        run_sum = '0; run_cnt = 0; res_valid = 0; res_sum = '0; res_cnt = 0;
        rst = 1'b1;
        cycle(0, 64'd0, 0, 0, 0);
        cycle(1, 64'd77, 1, 0, 1);
        rst = 1'b0;
        check("reset_sum", 80'(wb.out_sum), 80'd0);

        // Three-term run popped immediately.
        cycle(1, 64'd5, 0, 0, 1);
        cycle(1, 64'd7, 0, 0, 1);
        cycle(1, 64'h1_0000_0000, 1, 0, 1);
        check("tp1_sum",   80'(wb.out_sum),   80'h1_0000_000C);
        check("tp1_count", 80'(wb.out_count), 80'd3);
        cycle(0, 64'd0, 0, 0, 1);
        check("tp1_popped", 80'(wb.out_valid), 80'd0);

        // Held result under backpressure.
        cycle(1, 64'd42, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 64'd99, 1, 0, 0);
            check("tp2_ready", 80'(last_ready),   80'd0);
            check("tp2_sum",   80'(wb.out_sum),   80'd42);
            check("tp2_count", 80'(wb.out_count), 80'd1);
        end
        cycle(0, 64'd0, 0, 0, 1);
        check("tp2_popped", 80'(wb.out_valid), 80'd0);

        // Back-to-back runs with no idle cycles.
        k = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1, bb_val[i], bb_last[i], 0, 1);
            check("tp3_ready", 80'(last_ready), 80'd1);
            if (wb.out_valid && k < 3) begin
                check("tp3_sum",   80'(wb.out_sum),   bb_sum[k]);
                check("tp3_count", 80'(wb.out_count), 80'(bb_cnt[k]));
                k++;
            end
        end
        check("tp3_results", 80'(k), 80'd3);
        cycle(0, 64'd0, 0, 0, 1);

        // Narrow instance overflow, then a clean run.
        cycle(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1);
        cycle(1, 64'd2, 1, 0, 1);
        check("tp4_sum", 80'(nb.out_sum),      80'd1);
        check("tp4_ovf", 80'(nb.out_overflow), 80'd1);
        cycle(1, 64'd5, 1, 0, 1);
        check("tp4_sum2", 80'(nb.out_sum),      80'd5);
        check("tp4_ovf2", 80'(nb.out_overflow), 80'd0);
        cycle(0, 64'd0, 0, 0, 1);

        // Forced close at MAX_TERMS.
        for (int i = 0; i < int'(MAX_TERMS); i++) cycle(1, 64'd1, 0, 0, 1);
        check("tp5_valid", 80'(wb.out_valid), 80'd1);
        check("tp5_sum",   80'(wb.out_sum),   80'd256);
        check("tp5_count", 80'(wb.out_count), 80'd256);
        cycle(1, 64'd1, 0, 0, 1);
        check("tp5_popped", 80'(wb.out_valid), 80'd0);
        cycle(1, 64'd1, 1, 0, 1);
        check("tp5_next", 80'(wb.out_count), 80'd2);
        cycle(0, 64'd0, 0, 0, 1);

        // Clear mid-run drops the presented beat.
        cycle(1, 64'd9, 0, 0, 1);
        cycle(1, 64'd9, 0, 0, 1);
        cycle(1, 64'd100, 0, 1, 1);
        cycle(1, 64'd4, 1, 0, 1);
        check("tp6_sum",   80'(wb.out_sum),   80'd4);
        check("tp6_count", 80'(wb.out_count), 80'd1);
        // Clear while a result is popped.
        cycle(1, 64'd50, 1, 1, 1);
        check("tp6_clr_done", 80'(wb.out_valid), 80'd0);

        // Reset with a result pending.
        cycle(1, 64'd9, 1, 0, 0);
        rst = 1'b1;
        cycle(0, 64'd0, 0, 0, 0);
        rst = 1'b0;
        check("tp6_rst_valid", 80'(wb.out_valid), 80'd0);
        check("tp6_rst_sum",   80'(wb.out_sum),   80'd0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [63:0] p;
            p = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1000));
            rst = ($urandom_range(0, 299) == 0);
            cycle($urandom_range(0, 3) != 0, p, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 64-bit unsigned product stream from the pipelined multiplier.
- Sums a run of products terminated by a last flag, as in a dot product, into a wide accumulator.
- Presents the sum, the term count and a sticky overflow flag on a valid/ready output.
- Accepts a new run in the same cycle the previous result is popped, so back-to-back runs need no idle cycles.

Parameters:
- ACC_W, 72: accumulator and result width in bits; must be >= 64.
- MAX_TERMS, 256: maximum terms per run; reaching it force-closes the run.
- CNT_W, 9: term-count width; must satisfy 2^CNT_W > MAX_TERMS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_product/in_last hold a valid beat.
- in_ready  out  1  block can accept a beat this cycle.
- in_product  in  64  unsigned product from the multiplier.
- in_last  in  1  this beat is the final term of the run.
- clear  in  1  synchronous abort of the current run.
- out_valid  out  1  result registers are valid.
- out_ready  in  1  downstream takes the result.
- out_sum  out  ACC_W  sum of the run's terms, modulo 2^ACC_W.
- out_count  out  CNT_W  number of terms in the run, from 1 to MAX_TERMS.
- out_overflow  out  1  some addition in the run carried out of ACC_W.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- State machine: two states, ACCUM and DONE.
- Reset value: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_overflow=0.
- in_ready is combinational: 1 in ACCUM, or in DONE when out_ready=1. It is 0 while rst=1.
- Accept: a beat is accepted when in_valid & in_ready.
- Accumulate:
  - The base is acc/cnt/ovf in ACCUM, and 0/0/0 in DONE (a new run starts).
  - sum = base_acc + zero-extended in_product, computed ACC_W+1 wide.
  - acc <= sum[ACC_W-1:0]; cnt <= base_cnt+1; ovf <= base_ovf | sum[ACC_W].
- Close: an accepted beat closes the run when in_last=1 or base_cnt+1 == MAX_TERMS. On close:
  - the next-cycle values of acc/cnt/ovf are loaded into out_sum/out_count/out_overflow;
  - out_valid <= 1; state <= DONE;
  - acc/cnt/ovf <= 0.
- Latency: the result is visible on the cycle after the closing beat is accepted.
- DONE:
  - Output registers are stable while out_valid=1 and out_ready=0; in_ready=0.
  - out_valid & out_ready with no accepted beat: out_valid <= 0, state <= ACCUM.
  - out_valid & out_ready with an accepted beat: the pop and the first term of the new run happen in the same cycle. State goes to ACCUM, or stays DONE with new outputs if that beat also closes the run.
- clear:
  - In ACCUM: acc/cnt/ovf <= 0, and any beat presented that cycle is dropped (in_ready still reads 1).
  - In DONE: does not affect the output registers; the handshake still completes. A beat accepted in that cycle is dropped and the run starts empty.
- A run of zero terms is impossible; out_count is never 0 when out_valid=1.
- Overflow is sticky per run and cleared at the start of the next run. out_sum holds the wrapped value.
- Reset mid-run or while out_valid=1: all state returns to its reset value on the next edge; the pending result is lost.
- No combinational path from in_valid to in_ready. The path from out_ready to in_ready is allowed.

Test Plan:
- Three beats 5, 7, 0x1_0000_0000 (last on the third) with out_ready=1 -> one cycle later out_valid=1, out_sum=0x1_0000_000C, out_count=3, out_overflow=0. After the pop, out_valid=0.
- Single beat 42 with last=1 while out_ready=0 for 4 cycles -> outputs 42/1/0 held stable and in_ready=0 throughout. Raising out_ready pops them.
- Back-to-back runs {1,2 last}, {10 last}, {3,4 last} with out_ready=1 and in_valid held high -> in_ready is never low. Results are 3/2, 10/1, 7/2 on consecutive valid windows.
- ACC_W=64, beats 0xFFFF_FFFF_FFFF_FFFF and 2 (last) -> out_sum=1, out_count=2, out_overflow=1. The next run of {5 last} gives overflow=0.
- 256 beats of value 1, no last -> the run closes on the 256th beat with out_sum=256 and out_count=256. Beat 257 starts a new run.
- Accumulate 9 and 9, then clear, then 4 (last) -> out_sum=4, out_count=1. Separately, rst asserted while out_valid=1 -> the next cycle shows out_valid=0 and out_sum=0.
